// File: rtl/mem_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch and data access.
// Data wins arbitration unless fetch has waited MAX_WAIT cycles; each access runs grant -> issue -> respond.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic              ifGnt,
  output logic              ifValid,
  output logic [DATA_W-1:0] ifData,
  input  logic              dmReq,
  input  logic              dmWe,
  input  logic [ADDR_W-1:0] dmAddr,
  input  logic [DATA_W-1:0] dmWData,
  output logic              dmGnt,
  output logic              dmValid,
  output logic [DATA_W-1:0] dmRData,
  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDIn,
  input  logic [DATA_W-1:0] memDOut
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
  localparam int unsigned STV_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                gnt_if;
  logic                gnt_dm;
  logic                grant;
  logic [CNT_W-1:0]    cnt_q;
  logic [STV_W-1:0]    starve_q;
  logic                starved;
  logic                first_beat;
  logic                last_beat;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;
  logic                owner_if_q;

  assign starved    = (starve_q >= STV_W'(MAX_WAIT));
  assign first_beat = (cnt_q == CNT_W'(MEM_LAT));
  assign last_beat  = (cnt_q == CNT_W'(1));
  assign grant      = gnt_if | gnt_dm;

  // State register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and arbitration; grants exist only in IDLE
  always_comb begin
    state_d = state_q;
    gnt_if  = 1'b0;
    gnt_dm  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ifReq && starved) begin
          gnt_if  = 1'b1;
          state_d = BUSY;
        end else if (dmReq) begin
          gnt_dm  = 1'b1;
          state_d = BUSY;
        end else if (ifReq) begin
          gnt_if  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (last_beat) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the winning request at grant
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      owner_if_q <= 1'b0;
    end else if (grant) begin
      owner_if_q <= gnt_if;
      addr_q     <= gnt_if ? ifAddr : dmAddr;
      we_q       <= gnt_dm & dmWe;
      wdata_q    <= gnt_dm ? dmWData : '0;
    end
  end

  // Memory latency down-counter, loaded at grant
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q <= '0;
    end else if (grant) begin
      cnt_q <= CNT_W'(MEM_LAT);
    end else if (state_q == BUSY && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Fetch starvation counter, saturating at MAX_WAIT
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      starve_q <= '0;
    end else if (gnt_if) begin
      starve_q <= '0;
    end else if (ifReq && !starved) begin
      starve_q <= starve_q + STV_W'(1);
    end
  end

  // Capture read data on the last issue cycle; writes report zero
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ifData  <= '0;
      dmRData <= '0;
    end else if (state_q == BUSY && last_beat) begin
      if (owner_if_q) begin
        ifData <= we_q ? '0 : memDOut;
      end else begin
        dmRData <= we_q ? '0 : memDOut;
      end
    end
  end

  assign ifGnt   = gnt_if;
  assign dmGnt   = gnt_dm;
  assign memEn   = (state_q == BUSY);
  assign memWe   = memEn & first_beat & we_q;
  assign memAddr = memEn ? addr_q : '0;
  assign memDIn  = memEn ? wdata_q : '0;
  assign ifValid = (state_q == RESP) &  owner_if_q;
  assign dmValid = (state_q == RESP) & ~owner_if_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;
  localparam int unsigned MW  = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic          ifReq, ifGnt, ifValid;
  logic [AW-1:0] ifAddr;
  logic [DW-1:0] ifData;
  logic          dmReq, dmWe, dmGnt, dmValid;
  logic [AW-1:0] dmAddr;
  logic [DW-1:0] dmWData, dmRData;
  logic          memEn, memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memDIn, memDOut;

  logic          s_ifReq, s_ifGnt, s_ifValid;
  logic [DW-1:0] s_ifData;
  logic          s_dmReq, s_dmGnt, s_dmValid;
  logic [DW-1:0] s_dmRData;
  logic          s_memEn, s_memWe;
  logic [AW-1:0] s_memAddr;
  logic [DW-1:0] s_memDIn, s_memDOut;

  int checks = 0;
  int errors = 0;

  logic [31:0] dev_mem [16];
  logic        force_en;
  logic [31:0] force_dout;

  always #5 clk = ~clk;

  // Memory device behind the main DUT; force_* overrides read data for directed cases
  always @(posedge clk) if (memEn && memWe) dev_mem[memAddr[5:2]] <= memDIn;
  assign memDOut   = force_en ? force_dout : dev_mem[memAddr[5:2]];
  assign s_memDOut = ~s_memAddr;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_WAIT(MW)) u_dut (
    .clk(clk), .rstN(rstN),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifValid(ifValid), .ifData(ifData),
    .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr), .dmWData(dmWData),
    .dmGnt(dmGnt), .dmValid(dmValid), .dmRData(dmRData),
    .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memDIn(memDIn), .memDOut(memDOut)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_WAIT(MW)) u_dut_lat1 (
    .clk(clk), .rstN(rstN),
    .ifReq(s_ifReq), .ifAddr(32'h200), .ifGnt(s_ifGnt), .ifValid(s_ifValid), .ifData(s_ifData),
    .dmReq(s_dmReq), .dmWe(1'b0), .dmAddr(32'h300), .dmWData(32'h0),
    .dmGnt(s_dmGnt), .dmValid(s_dmValid), .dmRData(s_dmRData),
    .memEn(s_memEn), .memWe(s_memWe), .memAddr(s_memAddr), .memDIn(s_memDIn), .memDOut(s_memDOut)
  );

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; ifReq = 0; ifAddr = '0; dmReq = 0; dmWe = 0; dmAddr = '0; dmWData = '0;
    s_ifReq = 0; s_dmReq = 0; force_en = 0; force_dout = '0;
    #3;
    checks++; if ({ifGnt, dmGnt, ifValid, dmValid, memEn, memWe} !== 6'b0) begin errors++; $display("FAIL reset_ctl got=%b exp=000000", {ifGnt, dmGnt, ifValid, dmValid, memEn, memWe}); end
    checks++; if ({ifData, dmRData, memAddr, memDIn} !== 128'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", {ifData, dmRData, memAddr, memDIn}); end
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
  endtask

  task automatic test_fetch();
    tick(); ifAddr = 32'h40; ifReq = 1; force_en = 1; force_dout = 32'hDEADBEEF; #1;
    checks++; if ({ifGnt, dmGnt, memEn} !== 3'b100) begin errors++; $display("FAIL fetch_c0 got=%b exp=100", {ifGnt, dmGnt, memEn}); end
    tick(); ifReq = 0; #1;
    checks++; if ({memEn, memWe, ifValid} !== 3'b100 || memAddr !== 32'h40) begin errors++; $display("FAIL fetch_c1 got=%b/%h exp=100/40", {memEn, memWe, ifValid}, memAddr); end
    tick(); #1;
    checks++; if (memEn !== 1'b1 || memAddr !== 32'h40 || ifValid !== 1'b0) begin errors++; $display("FAIL fetch_c2 got=%b/%h/%b exp=1/40/0", memEn, memAddr, ifValid); end
    tick(); #1;
    checks++; if ({ifValid, dmValid, memEn} !== 3'b100 || ifData !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_c3 got=%b/%h exp=100/deadbeef", {ifValid, dmValid, memEn}, ifData); end
    tick(); ifReq = 1; ifAddr = 32'h44; #1;
    checks++; if ({ifValid, ifGnt} !== 2'b01 || ifData !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_c4 got=%b/%h exp=01/deadbeef", {ifValid, ifGnt}, ifData); end
    tick(); ifReq = 0;
    repeat (LAT + 1) tick();
    force_en = 0;
  endtask

  task automatic test_priority();
    force_en = 1; force_dout = 32'h0BADF00D;
    tick(); ifReq = 1; ifAddr = 32'h48; dmReq = 1; dmWe = 0; dmAddr = 32'h80; #1;
    checks++; if ({ifGnt, dmGnt} !== 2'b01) begin errors++; $display("FAIL prio_c0 got=%b exp=01", {ifGnt, dmGnt}); end
    tick(); dmReq = 0; #1;
    checks++; if ({ifGnt, dmGnt} !== 2'b00) begin errors++; $display("FAIL prio_c1 got=%b exp=00", {ifGnt, dmGnt}); end
    tick(); #1;
    tick(); #1;
    checks++; if ({ifGnt, dmGnt, ifValid, dmValid} !== 4'b0001 || dmRData !== 32'h0BADF00D) begin errors++; $display("FAIL prio_c3 got=%b/%h exp=0001/0badf00d", {ifGnt, dmGnt, ifValid, dmValid}, dmRData); end
    tick(); #1;
    checks++; if ({ifGnt, dmGnt} !== 2'b10) begin errors++; $display("FAIL prio_c4 got=%b exp=10", {ifGnt, dmGnt}); end
    tick(); ifReq = 0;
    tick(); tick(); #1;
    checks++; if ({ifValid, dmValid} !== 2'b10 || ifData !== 32'h0BADF00D) begin errors++; $display("FAIL prio_c7 got=%b/%h exp=10/0badf00d", {ifValid, dmValid}, ifData); end
    tick();
    force_en = 0;
  endtask

  task automatic test_write_read();
    tick(); dmReq = 1; dmWe = 1; dmAddr = 32'h100; dmWData = 32'h12345678; #1;
    checks++; if (dmGnt !== 1'b1) begin errors++; $display("FAIL wr_gnt got=%b exp=1", dmGnt); end
    tick(); dmReq = 0; dmWe = 0; #1;
    checks++; if ({memEn, memWe} !== 2'b11 || memDIn !== 32'h12345678 || memAddr !== 32'h100) begin errors++; $display("FAIL wr_c1 got=%b/%h/%h exp=11/12345678/100", {memEn, memWe}, memDIn, memAddr); end
    tick(); #1;
    checks++; if ({memEn, memWe} !== 2'b10) begin errors++; $display("FAIL wr_c2 got=%b exp=10", {memEn, memWe}); end
    tick(); #1;
    checks++; if (dmValid !== 1'b1 || dmRData !== 32'h0) begin errors++; $display("FAIL wr_c3 got=%b/%h exp=1/0", dmValid, dmRData); end
    tick(); dmReq = 1; dmAddr = 32'h100; #1;
    checks++; if (dmGnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got=%b exp=1", dmGnt); end
    tick(); dmReq = 0;
    tick(); tick(); #1;
    checks++; if (dmValid !== 1'b1 || dmRData !== 32'h12345678) begin errors++; $display("FAIL rd_back got=%b/%h exp=1/12345678", dmValid, dmRData); end
    tick();
  endtask

  task automatic test_drop_after_grant();
    force_en = 1; force_dout = 32'hCAFE0001;
    tick(); ifReq = 1; ifAddr = 32'h4C; #1;
    checks++; if (ifGnt !== 1'b1) begin errors++; $display("FAIL drop_gnt got=%b exp=1", ifGnt); end
    tick(); ifReq = 0;
    tick(); tick(); #1;
    checks++; if (ifValid !== 1'b1 || ifData !== 32'hCAFE0001) begin errors++; $display("FAIL drop_valid got=%b/%h exp=1/cafe0001", ifValid, ifData); end
    for (int c = 4; c <= 6; c++) begin
      tick(); #1;
      checks++; if ({ifGnt, memEn, ifValid} !== 3'b000) begin errors++; $display("FAIL drop_idle c%0d got=%b exp=000", c, {ifGnt, memEn, ifValid}); end
    end
    force_en = 0;
  endtask

  task automatic test_reset_mid_write();
    tick(); dmReq = 1; dmWe = 1; dmAddr = 32'h104; dmWData = 32'hA5A5A5A5; #1;
    checks++; if (dmGnt !== 1'b1) begin errors++; $display("FAIL rstw_gnt got=%b exp=1", dmGnt); end
    tick(); dmReq = 0; dmWe = 0; #1;
    checks++; if (memWe !== 1'b1) begin errors++; $display("FAIL rstw_we got=%b exp=1", memWe); end
    rstN = 1'b0; #1;
    checks++; if ({ifGnt, dmGnt, ifValid, dmValid, memEn, memWe} !== 6'b0) begin errors++; $display("FAIL rstw_ctl got=%b exp=000000", {ifGnt, dmGnt, ifValid, dmValid, memEn, memWe}); end
    checks++; if ({ifData, dmRData, memAddr, memDIn} !== 128'h0) begin errors++; $display("FAIL rstw_data got=%h exp=0", {ifData, dmRData, memAddr, memDIn}); end
    @(negedge clk); @(negedge clk) rstN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(); #1;
      checks++; if ({ifValid, dmValid, memEn} !== 3'b000) begin errors++; $display("FAIL rstw_quiet c%0d got=%b exp=000", c, {ifValid, dmValid, memEn}); end
    end
    tick(); ifReq = 1; ifAddr = 32'h50; #1;
    checks++; if (ifGnt !== 1'b1) begin errors++; $display("FAIL rstw_regrant got=%b exp=1", ifGnt); end
    tick(); ifReq = 0;
    repeat (LAT + 1) tick();
  endtask

  // MEM_LAT=1 instance: both requests held, fetch must break through after MAX_WAIT waits
  task automatic test_starvation();
    logic [3:0] exp;
    tick(); s_ifReq = 1; s_dmReq = 1;
    for (int c = 0; c <= 9; c++) begin
      #1;
      exp = 4'b0000;
      if (c == 6) exp[3] = 1'b1;
      if (c == 0 || c == 3 || c == 9) exp[2] = 1'b1;
      if (c == 8) exp[1] = 1'b1;
      if (c == 2 || c == 5) exp[0] = 1'b1;
      checks++; if ({s_ifGnt, s_dmGnt, s_ifValid, s_dmValid} !== exp) begin errors++; $display("FAIL starve c%0d got=%b exp=%b", c, {s_ifGnt, s_dmGnt, s_ifValid, s_dmValid}, exp); end
      if (c == 1) begin
        checks++; if ({s_memEn, s_memWe} !== 2'b10 || s_memDIn !== 32'h0) begin errors++; $display("FAIL starve_mem got=%b/%h exp=10/0", {s_memEn, s_memWe}, s_memDIn); end
      end
      if (c == 2) begin
        checks++; if (s_dmRData !== ~32'h300) begin errors++; $display("FAIL starve_dmdata got=%h exp=%h", s_dmRData, ~32'h300); end
      end
      if (c == 8) begin
        checks++; if (s_ifData !== ~32'h200) begin errors++; $display("FAIL starve_ifdata got=%h exp=%h", s_ifData, ~32'h200); end
      end
      tick();
    end
    s_ifReq = 0; s_dmReq = 0;
    repeat (4) tick();
  endtask

  // Random traffic against a transaction-timeline model
  task automatic test_random();
    int cyc, next_free, g, starve;
    bit act, t_if, t_we, e_if, e_dm, e_en, e_we, resp, pif, pdm;
    logic [31:0] t_addr, t_data, x_if, x_dm;
    logic [31:0] m_mem [16];
    logic [5:0] e_ctl, a_ctl;
    for (int i = 0; i < 16; i++) begin
      tick(); dmReq = 1; dmWe = 1; dmAddr = {26'd0, 4'(i), 2'b00}; dmWData = $urandom(); m_mem[i] = dmWData; #1;
      checks++; if (dmGnt !== 1'b1) begin errors++; $display("FAIL preload_gnt %0d got=%b exp=1", i, dmGnt); end
      tick(); dmReq = 0; dmWe = 0;
      repeat (LAT + 1) tick();
    end
    do_reset();
    cyc = 0; next_free = 0; act = 0; g = 0; starve = 0; t_if = 0; t_we = 0;
    t_addr = '0; t_data = '0; x_if = '0; x_dm = '0; pif = 0; pdm = 0;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      if (!ifReq || pif) begin ifReq = ($urandom_range(1) == 0); ifAddr = $urandom(); end
      else if ($urandom_range(15) == 0) ifReq = 0;
      if (!dmReq || pdm) begin
        dmReq = ($urandom_range(3) != 0); dmWe = 1'($urandom_range(1)); dmAddr = $urandom(); dmWData = $urandom();
      end else if ($urandom_range(15) == 0) dmReq = 0;
      @(negedge clk);
      e_if = (cyc >= next_free) && ifReq && (starve >= MW || !dmReq);
      e_dm = (cyc >= next_free) && dmReq && !e_if;
      e_en = act && cyc >= g + 1 && cyc <= g + LAT;
      e_we = act && cyc == g + 1 && t_we;
      resp = act && cyc == g + LAT + 1;
      if (resp && t_if) x_if = t_data;
      if (resp && !t_if) x_dm = t_data;
      e_ctl = {e_if, e_dm, e_en, e_we, resp && t_if, resp && !t_if};
      a_ctl = {ifGnt, dmGnt, memEn, memWe, ifValid, dmValid};
      checks++; if (a_ctl !== e_ctl) begin errors++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", cyc, a_ctl, e_ctl); end
      checks++; if (ifData !== x_if || dmRData !== x_dm) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h/%h exp=%h/%h", cyc, ifData, dmRData, x_if, x_dm); end
      if (e_en) begin
        checks++; if (memAddr !== t_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, memAddr, t_addr); end
      end
      if (e_we) begin
        checks++; if (memDIn !== m_mem[t_addr[5:2]]) begin errors++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, memDIn, m_mem[t_addr[5:2]]); end
      end
      if (resp) act = 0;
      if (e_if || e_dm) begin
        act = 1; g = cyc; t_if = e_if; next_free = cyc + LAT + 2;
        t_addr = e_if ? ifAddr : dmAddr;
        t_we = e_dm && dmWe;
        if (t_we) begin
          m_mem[t_addr[5:2]] = dmWData;
          t_data = '0;
        end else begin
          t_data = m_mem[t_addr[5:2]];
        end
      end
      if (e_if) starve = 0;
      else if (ifReq && starve < MW) starve++;
      pif = e_if; pdm = e_dm;
      cyc++;
    end
    ifReq = 0; dmReq = 0;
    repeat (LAT + 3) tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_write_read();
    test_drop_after_grant();
    test_reset_mid_write();
    test_starvation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
